// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester sram-like arbiter sharing one downstream memory port.
//
// The instruction and data requesters compete for the mem_* request channel. The
// winner's request fields are forwarded combinationally. If the memory does not
// accept the address immediately, the grant is held on that requester until it is
// accepted or the requester withdraws. Each accepted address pushes a 1-bit
// requester ID (0 = inst, 1 = data) into an in-order FIFO. Returning data
// (mem_data_ok) pops the head ID and is routed to the matching requester.
//
// Parameters:
//   OST_DEPTH  maximum outstanding address-accepted / data-pending transactions
//              (2, 4 or 8)
//
// Configuration macro:
//   ARB_RR_EN  when defined, contention in IDLE is resolved round-robin using a
//              last-grant register. When undefined, data always beats inst.
//
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   inst_req/wr/size/wstrb/addr/wdata   instruction request
//   inst_addr_ok/data_ok/rdata          instruction handshake and read data
//   data_req/wr/size/wstrb/addr/wdata   data request
//   data_addr_ok/data_ok/rdata          data handshake and read data
//   mem_req/wr/size/wstrb/addr/wdata    shared downstream request
//   mem_addr_ok/data_ok/rdata           downstream handshake, in-order responses
module mem_arbiter #(
    parameter int unsigned OST_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PtrW = $clog2(OST_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(OST_DEPTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StHoldI,
        StHoldD
    } state_e;

    state_e state_q;

    logic                 gnt_valid;
    logic                 gnt_data;
    logic                 full;
    logic                 accept;
    logic                 pop;
    logic                 head_id;

    logic [OST_DEPTH-1:0] id_fifo_q;
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      count_q;

`ifdef ARB_RR_EN
    // 1 when the data requester won the most recent accept.
    logic last_data_q;
`endif

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = 1'b0;
        unique case (state_q)
            StHoldI: begin
                gnt_valid = inst_req;
                gnt_data  = 1'b0;
            end
            StHoldD: begin
                gnt_valid = data_req;
                gnt_data  = 1'b1;
            end
            default: begin
                gnt_valid = data_req | inst_req;
`ifdef ARB_RR_EN
                // Under contention, favour whoever did not win last time.
                gnt_data  = data_req & (~inst_req | ~last_data_q);
`else
                gnt_data  = data_req;
`endif
            end
        endcase
    end

    assign full = (count_q == CntFull);

    // resetn gates the request so nothing is offered while reset is held.
    assign mem_req   = resetn & gnt_valid & ~full;
    assign mem_wr    = gnt_data ? data_wr    : inst_wr;
    assign mem_size  = gnt_data ? data_size  : inst_size;
    assign mem_wstrb = gnt_data ? data_wstrb : inst_wstrb;
    assign mem_addr  = gnt_data ? data_addr  : inst_addr;
    assign mem_wdata = gnt_data ? data_wdata : inst_wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & ~gnt_data;
    assign data_addr_ok = accept &  gnt_data;

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    assign pop          = mem_data_ok & (count_q != '0);
    assign head_id      = id_fifo_q[rd_ptr_q];
    assign inst_data_ok = pop & ~head_id;
    assign data_data_ok = pop &  head_id;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_req && !mem_addr_ok) begin
                        state_q <= gnt_data ? StHoldD : StHoldI;
                    end
                end
                StHoldI, StHoldD: begin
                    // Leave on accept, or when the held requester withdraws.
                    if (!gnt_valid || accept) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_data_q <= 1'b0;  // data gets first pick after reset
        end else if (accept) begin
            last_data_q <= gnt_data;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outstanding-ID FIFO
    // ------------------------------------------------------------------
    // Storage needs no reset: entries are only read when count_q is non-zero.
    always_ff @(posedge clk) begin
        if (accept) begin
            id_fifo_q[wr_ptr_q] <= gnt_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            unique case ({accept, pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned OST = 4;

    logic        clk = 1'b0;
    logic        resetn;

    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;

    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model state: queue of requester IDs whose data is still pending,
    // which requester (if any) currently owns a held grant, and who won last.
    bit sb_q[$];
    int occ_snap = 0;
    int held = -1;
    int last_win = 0;

    mem_arbiter #(.OST_DEPTH(OST)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Occupancy as seen at the start of the cycle, shared by both checkers.
    always @(posedge clk) begin
        #2;
        occ_snap = sb_q.size();
    end

    // Request-side checker: predicts the grant and pushes accepted IDs.
    always @(negedge clk) begin : req_chk
        int  w;
        bit  full, emr, acc;
        if (!resetn) begin
            chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
            chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        end else begin
            full = (occ_snap == OST);
            if (held >= 0) begin
                if ((held == 1 && data_req) || (held == 0 && inst_req)) w = held;
                else w = -1;
            end else if (data_req && inst_req) begin
`ifdef ARB_RR_EN
                w = (last_win == 1) ? 0 : 1;
`else
                w = 1;
`endif
            end else if (data_req) begin
                w = 1;
            end else if (inst_req) begin
                w = 0;
            end else begin
                w = -1;
            end
            emr = (w >= 0) && !full;
            acc = emr && mem_addr_ok;
            chk("mem_req", {31'd0, mem_req}, {31'd0, emr});
            if (emr) begin
                chk("mem_addr",  mem_addr,  (w == 1) ? data_addr  : inst_addr);
                chk("mem_wdata", mem_wdata, (w == 1) ? data_wdata : inst_wdata);
                chk("mem_ctrl", {25'd0, mem_wr, mem_size, mem_wstrb},
                    (w == 1) ? {25'd0, data_wr, data_size, data_wstrb}
                             : {25'd0, inst_wr, inst_size, inst_wstrb});
            end
            chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, acc && w == 0});
            chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, acc && w == 1});
            if (acc) begin
                sb_q.push_back(w == 1);
                held = -1;
                last_win = w;
            end else if (emr) begin
                held = w;
            end else if (w < 0) begin
                held = -1;
            end
        end
    end

    // Response monitor: pops the oldest expected ID whenever data returns.
    always @(negedge clk) begin : rsp_mon
        bit pop, id;
        #1;
        if (!resetn) begin
            chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        end else begin
            pop = mem_data_ok && (occ_snap > 0);
            id  = 1'b0;
            if (pop) id = sb_q.pop_front();
            chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, pop && !id});
            chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, pop && id});
            chk("inst_rdata", inst_rdata, mem_rdata);
            chk("data_rdata", data_rdata, mem_rdata);
        end
    end

    // Drive one cycle of control inputs; fields are left as set by the caller.
    task automatic cyc(input bit ir, input bit dr, input bit aok, input bit dok);
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        sb_q.delete();
        held     = -1;
        last_win = 0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        resetn = 1'b1;
    endtask

    task automatic set_fixed_addrs();
        inst_addr  = 32'h1c000000;
        data_addr  = 32'h00001000;
        inst_wr = 1'b0; data_wr = 1'b1;
        inst_size = 2'd2; data_size = 2'd2;
        inst_wstrb = 4'h0; data_wstrb = 4'hf;
        inst_wdata = 32'h0; data_wdata = 32'hcafef00d;
    endtask

    task automatic randomize_fields();
        inst_addr  = $urandom;
        data_addr  = $urandom;
        inst_wdata = $urandom;
        data_wdata = $urandom;
        inst_wr    = 1'($urandom);
        data_wr    = 1'($urandom);
        inst_size  = 2'($urandom);
        data_size  = 2'($urandom);
        inst_wstrb = 4'($urandom);
        data_wstrb = 4'($urandom);
    endtask

    initial begin
        resetn = 1'b0;
        set_fixed_addrs();
        inst_req = 1'b1; data_req = 1'b1;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Contention with immediate accept: data first, then inst; return D, I.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Held data grant for 3 cycles while inst joins in cycle 2.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Fill to OST_DEPTH with inst, then one return frees a slot.
        for (int i = 0; i < OST; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        // Push and pop together at the boundary, then drain.
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < OST + 1; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Drop of a held request, then empty-FIFO data pulse.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset with two outstanding; later returns must be ignored.
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            randomize_fields();
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 1) != 0), ($urandom_range(0, 9) < 3));
            end
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
